// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants for the raster generator and all renderers.
// Renderers use H_START/V_START as visible-area origins; H_W/V_W size the counters.
package vga_timing_pkg;

    localparam int unsigned CLK_DIV = 4;    // board clocks per pixel
    localparam int unsigned H_TOTAL = 800;  // pixels per line
    localparam int unsigned H_SYNC  = 96;   // hSync low while hCount < H_SYNC
    localparam int unsigned H_START = 144;  // first visible hCount
    localparam int unsigned H_END   = 784;  // first non-visible hCount
    localparam int unsigned V_TOTAL = 525;  // lines per frame
    localparam int unsigned V_SYNC  = 2;    // vSync low while vCount < V_SYNC
    localparam int unsigned V_START = 35;   // first visible line
    localparam int unsigned V_END   = 515;  // first non-visible line

    localparam int unsigned H_W = 10;
    localparam int unsigned V_W = 10;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to its consumers.
//   master : generator side, drives every signal
//   slave  : renderer side, observes every signal
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic [H_W-1:0] hCount;
    logic [V_W-1:0] vCount;
    logic           bright;
    logic           hSync;
    logic           vSync;
    logic           pix_en;
    logic           line_tick;
    logic           frame_tick;

    modport master (
        output hCount, vCount, bright, hSync, vSync, pix_en, line_tick, frame_tick
    );

    modport slave (
        input  hCount, vCount, bright, hSync, vSync, pix_en, line_tick, frame_tick
    );

endinterface

// File: rtl/pixel_clk_div.sv
// Pixel-rate divider: pix_en is a registered one-clk strobe on the last
// clock of every CLK_DIV-clock pixel period.
//   clk    : board clock
//   rst    : async active-high reset (div=0, pix_en=0)
//   pix_en : strobe, high while the divider holds CLK_DIV-1
module pixel_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Wrap on equality with the last count.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
    end

    // pix_en is loaded from the next divider value so it equals (div == CLK_DIV-1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            pix_en <= 1'b0;
        end else begin
            div_q  <= div_d;
            pix_en <= (div_d == DIV_LAST);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: scan counters, registered sync/bright decode
// and line/frame ticks, all updating on the pixel advance edge.
//   clk : board clock
//   rst : async active-high reset
//   vga : master side of the timing bundle (hCount, vCount, bright,
//         hSync, vSync, pix_en, line_tick, frame_tick)
module vga_timing_gen #(
    parameter int unsigned CLK_DIV = vga_timing_pkg::CLK_DIV,
    parameter int unsigned H_TOTAL = vga_timing_pkg::H_TOTAL,
    parameter int unsigned H_SYNC  = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_START = vga_timing_pkg::H_START,
    parameter int unsigned H_END   = vga_timing_pkg::H_END,
    parameter int unsigned V_TOTAL = vga_timing_pkg::V_TOTAL,
    parameter int unsigned V_SYNC  = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_START = vga_timing_pkg::V_START,
    parameter int unsigned V_END   = vga_timing_pkg::V_END
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  vga
);
    import vga_timing_pkg::*;

    localparam logic [H_W-1:0] H_LAST  = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST  = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] H_SYNC_W  = H_W'(H_SYNC);
    localparam logic [H_W-1:0] H_START_W = H_W'(H_START);
    localparam logic [H_W-1:0] H_END_W   = H_W'(H_END);
    localparam logic [V_W-1:0] V_SYNC_W  = V_W'(V_SYNC);
    localparam logic [V_W-1:0] V_START_W = V_W'(V_START);
    localparam logic [V_W-1:0] V_END_W   = V_W'(V_END);

    logic           pix_en;
    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;
    logic           h_wrap_c, v_wrap_c;
    logic           hsync_q, vsync_q, bright_q;
    logic           line_tick_q, frame_tick_q;

    pixel_clk_div #(.CLK_DIV(CLK_DIV)) u_pixel_clk_div (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en)
    );

    // Next scan position; only moves on the advance edge.
    always_comb begin
        h_wrap_c = (h_q == H_LAST);
        v_wrap_c = (v_q == V_LAST);
        h_d      = h_q;
        v_d      = v_q;
        if (pix_en) begin
            if (h_wrap_c) begin
                h_d = '0;
                v_d = v_wrap_c ? '0 : v_q + V_W'(1);
            end else begin
                h_d = h_q + H_W'(1);
            end
        end
    end

    // Decode is taken from the next position so pins line up with the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q          <= '0;
            v_q          <= '0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            bright_q     <= 1'b0;
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            hsync_q      <= (h_d >= H_SYNC_W);
            vsync_q      <= (v_d >= V_SYNC_W);
            bright_q     <= (h_d >= H_START_W) && (h_d < H_END_W) &&
                            (v_d >= V_START_W) && (v_d < V_END_W);
            line_tick_q  <= pix_en && h_wrap_c;
            frame_tick_q <= pix_en && h_wrap_c && v_wrap_c;
        end
    end

    assign vga.hCount     = h_q;
    assign vga.vCount     = v_q;
    assign vga.bright     = bright_q;
    assign vga.hSync      = hsync_q;
    assign vga.vSync      = vsync_q;
    assign vga.pix_en     = pix_en;
    assign vga.line_tick  = line_tick_q;
    assign vga.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing for reset,
// release, one line and async reset; a shrunken instance for frame-level checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic d_rst = 1'b1;
    logic s_rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if d_if ();
    vga_timing_gen_if s_if ();

    vga_timing_gen u_dut (
        .clk (clk),
        .rst (d_rst),
        .vga (d_if)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_TOTAL(10), .H_SYNC(2), .H_START(3), .H_END(8),
        .V_TOTAL(5), .V_SYNC(1), .V_START(1), .V_END(4)
    ) u_small (
        .clk (clk),
        .rst (s_rst),
        .vga (s_if)
    );

    task automatic test_reset();
        int pulses;
        d_rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({d_if.hCount, d_if.vCount} !== 20'd0) begin
            fails++; $display("FAIL reset_counters: got h=%0d v=%0d, want 0,0", d_if.hCount, d_if.vCount);
        end
        tests++;
        if ({d_if.bright, d_if.hSync, d_if.vSync, d_if.pix_en, d_if.line_tick, d_if.frame_tick} !== 6'b0) begin
            fails++; $display("FAIL reset_flags: got b/hs/vs/pe/lt/ft=%b%b%b%b%b%b, want 000000",
                d_if.bright, d_if.hSync, d_if.vSync, d_if.pix_en, d_if.line_tick, d_if.frame_tick);
        end
        d_rst = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (d_if.pix_en === 1'b1) pulses++;
            if (k <= 3) begin
                tests++;
                if ({d_if.hCount, d_if.vCount, d_if.bright, d_if.hSync, d_if.vSync} !== 23'd0) begin
                    fails++; $display("FAIL release_hold_%0d: got h=%0d v=%0d b=%b hs=%b vs=%b, want all 0",
                        k, d_if.hCount, d_if.vCount, d_if.bright, d_if.hSync, d_if.vSync);
                end
            end
        end
        tests++;
        if (d_if.hCount !== 10'd1) begin
            fails++; $display("FAIL release_first_advance: got h=%0d, want 1", d_if.hCount);
        end
        tests++;
        if (pulses != 1) begin
            fails++; $display("FAIL release_pix_en_pulses: got %0d, want 1", pulses);
        end
    endtask

    task automatic test_line();
        int hs_low, lt_cnt, ft_cnt, br_cnt, first_hs;
        hs_low = 0; lt_cnt = 0; ft_cnt = 0; br_cnt = 0; first_hs = -1;
        d_rst = 1'b1;
        @(negedge clk);
        d_rst = 1'b0;
        for (int n = 0; n <= 3201; n++) begin
            if (n > 0) @(negedge clk);
            if (n <= 3199) begin
                if (d_if.hSync === 1'b0) hs_low++;
                if (d_if.hSync === 1'b1 && first_hs < 0) first_hs = n;
                if (d_if.bright === 1'b1) br_cnt++;
            end
            if (n >= 1 && n <= 3200) begin
                if (d_if.line_tick === 1'b1) lt_cnt++;
                if (d_if.frame_tick === 1'b1) ft_cnt++;
            end
            if (n == 3200) begin
                tests++;
                if ({d_if.line_tick, d_if.hCount, d_if.vCount} !== {1'b1, 10'd0, 10'd1}) begin
                    fails++; $display("FAIL line_wrap: got lt=%b h=%0d v=%0d, want lt=1 h=0 v=1",
                        d_if.line_tick, d_if.hCount, d_if.vCount);
                end
            end
            if (n == 3201) begin
                tests++;
                if (d_if.line_tick !== 1'b0) begin
                    fails++; $display("FAIL line_tick_width: got %b one clk later, want 0", d_if.line_tick);
                end
            end
        end
        tests++;
        if (hs_low != 384) begin
            fails++; $display("FAIL hsync_low_clks: got %0d, want 384", hs_low);
        end
        tests++;
        if (first_hs != 384) begin
            fails++; $display("FAIL hsync_rise_clk: got %0d, want 384", first_hs);
        end
        tests++;
        if (lt_cnt != 1 || ft_cnt != 0) begin
            fails++; $display("FAIL line_tick_count: got lt=%0d ft=%0d, want 1,0", lt_cnt, ft_cnt);
        end
        tests++;
        if (br_cnt != 0) begin
            fails++; $display("FAIL bright_line0: got %0d clks, want 0", br_cnt);
        end
    endtask

    task automatic test_async_reset();
        d_rst = 1'b1;
        @(negedge clk);
        d_rst = 1'b0;
        repeat (8000) @(negedge clk);
        tests++;
        if ({d_if.hCount, d_if.vCount, d_if.hSync, d_if.vSync} !== {10'd400, 10'd2, 1'b1, 1'b1}) begin
            fails++; $display("FAIL midline_pos: got h=%0d v=%0d hs=%b vs=%b, want 400,2,1,1",
                d_if.hCount, d_if.vCount, d_if.hSync, d_if.vSync);
        end
        #2 d_rst = 1'b1;
        #1;
        tests++;
        if ({d_if.hCount, d_if.vCount, d_if.hSync, d_if.vSync, d_if.bright, d_if.pix_en,
             d_if.line_tick, d_if.frame_tick} !== 26'd0) begin
            fails++; $display("FAIL async_reset_immediate: got h=%0d v=%0d hs=%b vs=%b, want 0,0,0,0",
                d_if.hCount, d_if.vCount, d_if.hSync, d_if.vSync);
        end
        @(negedge clk);
        d_rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({d_if.hCount, d_if.vCount, d_if.pix_en} !== {10'd0, 10'd0, 1'b1}) begin
            fails++; $display("FAIL async_release_hold: got h=%0d v=%0d pe=%b, want 0,0,1",
                d_if.hCount, d_if.vCount, d_if.pix_en);
        end
        @(negedge clk);
        tests++;
        if ({d_if.hCount, d_if.line_tick} !== {10'd1, 1'b0}) begin
            fails++; $display("FAIL async_release_advance: got h=%0d lt=%b, want 1,0",
                d_if.hCount, d_if.line_tick);
        end
    endtask

    // Small instance: 2 clk/px, 10 px/line, 5 lines/frame -> 20 clk/line, 100 clk/frame.
    task automatic test_small_frame();
        int p, h, v, br_cnt, vs_low, lt_cnt, first_br, last_br, ft_prev, ft_period, ft_cnt;
        logic [7:0] exp_f, got_f;
        br_cnt = 0; vs_low = 0; lt_cnt = 0; first_br = -1; last_br = -1;
        ft_prev = -1; ft_period = -1; ft_cnt = 0;
        s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0;
        for (int n = 0; n <= 200; n++) begin
            if (n > 0) @(negedge clk);
            p = n / 2;
            h = p % 10;
            v = (p / 10) % 5;
            exp_f = {(h >= 3 && h < 8 && v >= 1 && v < 4) ? 1'b1 : 1'b0,
                     (h >= 2) ? 1'b1 : 1'b0,
                     (v >= 1) ? 1'b1 : 1'b0,
                     (n % 2 == 1) ? 1'b1 : 1'b0,
                     (n > 0 && n % 20 == 0) ? 1'b1 : 1'b0,
                     (n > 0 && n % 100 == 0) ? 1'b1 : 1'b0,
                     2'b00};
            got_f = {s_if.bright, s_if.hSync, s_if.vSync, s_if.pix_en,
                     s_if.line_tick, s_if.frame_tick, 2'b00};
            tests++;
            if (s_if.hCount !== 10'(h) || s_if.vCount !== 10'(v) || got_f !== exp_f) begin
                fails++; $display("FAIL small_n%0d: got h=%0d v=%0d flags=%b, want h=%0d v=%0d flags=%b",
                    n, s_if.hCount, s_if.vCount, got_f[7:2], h, v, exp_f[7:2]);
            end
            if (n <= 99) begin
                if (s_if.bright === 1'b1) begin
                    br_cnt++;
                    if (first_br < 0) first_br = s_if.hCount * 16 + s_if.vCount;
                    last_br = s_if.hCount * 16 + s_if.vCount;
                end
                if (s_if.vSync === 1'b0) vs_low++;
            end
            if (n >= 1 && s_if.line_tick === 1'b1) lt_cnt++;
            if (s_if.frame_tick === 1'b1) begin
                ft_cnt++;
                if (ft_prev >= 0) ft_period = n - ft_prev;
                ft_prev = n;
            end
        end
        tests++;
        if (br_cnt != 30) begin
            fails++; $display("FAIL small_bright_clks: got %0d, want 30", br_cnt);
        end
        tests++;
        if (first_br != 3 * 16 + 1 || last_br != 7 * 16 + 3) begin
            fails++; $display("FAIL small_bright_bounds: got first=(%0d,%0d) last=(%0d,%0d), want (3,1) (7,3)",
                first_br / 16, first_br % 16, last_br / 16, last_br % 16);
        end
        tests++;
        if (vs_low != 20) begin
            fails++; $display("FAIL small_vsync_low: got %0d clks, want 20", vs_low);
        end
        tests++;
        if (lt_cnt != 10 || ft_cnt != 2 || ft_period != 100) begin
            fails++; $display("FAIL small_tick_periods: got lt=%0d ft=%0d period=%0d, want 10,2,100",
                lt_cnt, ft_cnt, ft_period);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_async_reset();
        test_small_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
